// File: rtl/coproc_issue_ctrl.sv
// Issue controller that sequences one request at a time through a fixed-latency comp_unit.
// Optional build macro CU_ILLEGAL_OP_EN: illegal ops skip the comp_unit and answer with rsp_err.
module coproc_issue_ctrl #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [15:0] req_imm,
    input  logic [3:0]  req_tag,
    output logic [3:0]  cu_operation,
    output logic [31:0] cu_rs1,
    output logic [31:0] cu_rs2,
    output logic [15:0] cu_immediate,
    input  logic [31:0] cu_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_tag,
    output logic        rsp_err,
    output logic [15:0] done_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  op_q;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [15:0] imm_q;
    logic [3:0]  tag_q;
    logic [3:0]  cnt_q;
    logic        accept;
    logic        rsp_done;
    logic        illegal_req;

`ifdef CU_ILLEGAL_OP_EN
    logic err_q;

    function automatic logic is_illegal(input logic [3:0] op);
        return (op == 4'h0) || (op > 4'hA);
    endfunction

    assign illegal_req = is_illegal(req_op);
    assign rsp_err     = err_q;
`else
    assign illegal_req = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    // req_ready is also held low while reset is asserted so every output reads zero then.
    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign rsp_done  = (state == RESP) && rsp_ready;
    assign rsp_tag   = tag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        rsp_valid    = 1'b0;
        cu_operation = 4'h0;
        cu_rs1       = 32'h0;
        cu_rs2       = 32'h0;
        cu_immediate = 16'h0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = illegal_req ? RESP : EXEC;
                end
            end
            EXEC: begin
                cu_operation = op_q;
                cu_rs1       = rs1_q;
                cu_rs2       = rs2_q;
                cu_immediate = imm_q;
                if (cnt_q == 4'h0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, latency countdown, result capture and completion count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= 4'h0;
            rs1_q      <= 32'h0;
            rs2_q      <= 32'h0;
            imm_q      <= 16'h0;
            tag_q      <= 4'h0;
            cnt_q      <= 4'h0;
            rsp_data   <= 32'h0;
            done_count <= 16'h0;
`ifdef CU_ILLEGAL_OP_EN
            err_q      <= 1'b0;
`endif
        end else begin
            if (accept) begin
                op_q  <= req_op;
                rs1_q <= req_rs1;
                rs2_q <= req_rs2;
                imm_q <= req_imm;
                tag_q <= req_tag;
                cnt_q <= CNT_INIT;
`ifdef CU_ILLEGAL_OP_EN
                err_q <= illegal_req;
                if (illegal_req) begin
                    rsp_data <= 32'h0;
                end
`endif
            end else if (state == EXEC) begin
                if (cnt_q == 4'h0) begin
                    rsp_data <= cu_out;
                end else begin
                    cnt_q <= cnt_q - 4'h1;
                end
            end
            if (rsp_done) begin
                done_count <= done_count + 16'h1;
            end
        end
    end

endmodule

// File: tb/tb_coproc_issue_ctrl.sv
// Directed bench for coproc_issue_ctrl with an XOR comp_unit stub of one register stage.
module tb_coproc_issue_ctrl;

    localparam int LATENCY = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [15:0] req_imm;
    logic [3:0]  req_tag;
    logic [3:0]  cu_operation;
    logic [31:0] cu_rs1;
    logic [31:0] cu_rs2;
    logic [15:0] cu_immediate;
    logic [31:0] cu_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic        rsp_err;
    logic [15:0] done_count;

    int checks   = 0;
    int failures = 0;

    coproc_issue_ctrl #(.LATENCY(LATENCY)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .req_imm      (req_imm),
        .req_tag      (req_tag),
        .cu_operation (cu_operation),
        .cu_rs1       (cu_rs1),
        .cu_rs2       (cu_rs2),
        .cu_immediate (cu_immediate),
        .cu_out       (cu_out),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_tag      (rsp_tag),
        .rsp_err      (rsp_err),
        .done_count   (done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) cu_out <= cu_rs1 ^ cu_rs2;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Presents one request at a negedge; returns one cycle after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [15:0] imm, input logic [3:0] tag);
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_imm   = imm;
        req_tag   = tag;
        tick();
        req_valid = 1'b0;
        req_op    = 4'hC;
        req_rs1   = 32'hFFFF_FFFF;
        req_rs2   = 32'h1357_9BDF;
        req_imm   = 16'hFFFF;
        req_tag   = 4'hE;
    endtask

    // n counts cycles after the accept cycle (accept cycle = 0) until rsp_valid is seen.
    task automatic wait_rsp(output int n);
        n = 1;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    logic [31:0] b2b_rs1 [4] = '{32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'hFFFF_0000, 32'h1234_5678};
    logic [31:0] b2b_rs2 [4] = '{32'h5A5A_5A5A, 32'h0F0F_0F0F, 32'h00FF_FF00, 32'h8765_4321};
    logic [31:0] b2b_exp [4] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFF00_FF00, 32'h9551_1559};
    int acc_cyc [4];
    int n;
    int idx;
    int rcnt;
    int seen;

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 4'h0;
        req_rs1   = 32'h0;
        req_rs2   = 32'h0;
        req_imm   = 16'h0;
        req_tag   = 4'h0;
        rsp_ready = 1'b1;

        #2;
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_done_count", done_count, 0);
        check_eq("rst_cu_operation", cu_operation, 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_rsp_tag", rsp_tag, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_eq("post_rst_req_ready", req_ready, 1);

        // Single operation
        issue(4'h1, 32'hF0F0_0000, 32'h0000_0F0F, 16'h0011, 4'd3);
        check_eq("single_exec_op", cu_operation, 4'h1);
        check_eq("single_exec_rs1", cu_rs1, 32'hF0F0_0000);
        check_eq("single_exec_imm", cu_immediate, 16'h0011);
        check_eq("single_exec_req_ready", req_ready, 0);
        wait_rsp(n);
        check_eq("single_rsp_latency", n, LATENCY + 1);
        check_eq("single_rsp_data", rsp_data, 32'hF0F0_0F0F);
        check_eq("single_rsp_tag", rsp_tag, 4'd3);
        check_eq("single_rsp_err", rsp_err, 0);
        check_eq("single_resp_cu_op", cu_operation, 0);
        tick();
        check_eq("single_rsp_valid_clr", rsp_valid, 0);
        check_eq("single_done_count", done_count, 1);
        check_eq("single_req_ready", req_ready, 1);

        // Backpressure with ignored request traffic while busy
        rsp_ready = 1'b0;
        issue(4'h2, 32'h1234_5678, 32'h0000_FFFF, 16'h0000, 4'd5);
        wait_rsp(n);
        check_eq("bp_latency", n, LATENCY + 1);
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_rsp_valid", rsp_valid, 1);
            check_eq("bp_rsp_data", rsp_data, 32'h1234_A987);
            check_eq("bp_rsp_tag", rsp_tag, 4'd5);
            check_eq("bp_req_ready", req_ready, 0);
            check_eq("bp_cu_operation", cu_operation, 0);
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check_eq("bp_rsp_valid_clr", rsp_valid, 0);
        check_eq("bp_done_count", done_count, 2);

        // Back-to-back with req_valid held high
        do_reset();
        check_eq("b2b_pre_done_count", done_count, 0);
        idx       = 0;
        rcnt      = 0;
        req_valid = 1'b1;
        req_op    = 4'h1;
        req_rs1   = b2b_rs1[0];
        req_rs2   = b2b_rs2[0];
        req_imm   = 16'h0;
        req_tag   = 4'd0;
        for (int cyc = 0; cyc < 40 && rcnt < 4; cyc++) begin
            if (rsp_valid) begin
                check_eq("b2b_rsp_tag", rsp_tag, rcnt);
                check_eq("b2b_rsp_data", rsp_data, b2b_exp[rcnt]);
                rcnt++;
            end
            seen = (req_valid && req_ready) ? 1 : 0;
            if (seen == 1) acc_cyc[idx] = cyc;
            tick();
            if (seen == 1) begin
                idx++;
                if (idx == 4) begin
                    req_valid = 1'b0;
                end else begin
                    req_op  = 4'(idx + 1);
                    req_rs1 = b2b_rs1[idx];
                    req_rs2 = b2b_rs2[idx];
                    req_tag = 4'(idx);
                end
            end
        end
        check_eq("b2b_rsp_count", rcnt, 4);
        check_eq("b2b_accept_count", idx, 4);
        for (int i = 1; i < 4; i++) begin
            check_eq("b2b_accept_spacing", acc_cyc[i] - acc_cyc[i-1], LATENCY + 2);
        end
        tick();
        check_eq("b2b_done_count", done_count, 4);

        // Illegal op
        issue(4'hF, 32'hDEAD_BEEF, 32'h0000_0000, 16'h0000, 4'd7);
`ifdef CU_ILLEGAL_OP_EN
        check_eq("illegal_rsp_valid_c1", rsp_valid, 1);
        check_eq("illegal_cu_op", cu_operation, 0);
        check_eq("illegal_rsp_err", rsp_err, 1);
        check_eq("illegal_rsp_data", rsp_data, 0);
        check_eq("illegal_rsp_tag", rsp_tag, 4'd7);
`else
        check_eq("illegal_exec_op", cu_operation, 4'hF);
        wait_rsp(n);
        check_eq("illegal_latency", n, LATENCY + 1);
        check_eq("illegal_rsp_err", rsp_err, 0);
        check_eq("illegal_rsp_data", rsp_data, 32'hDEAD_BEEF);
        check_eq("illegal_rsp_tag", rsp_tag, 4'd7);
`endif
        tick();
        check_eq("illegal_done_count", done_count, 5);

        // Asynchronous reset in the middle of EXEC
        issue(4'h3, 32'h0000_0001, 32'h0000_0002, 16'h0042, 4'd9);
        check_eq("rstmid_exec_op", cu_operation, 4'h3);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("rstmid_cu_operation", cu_operation, 0);
        check_eq("rstmid_cu_rs1", cu_rs1, 0);
        check_eq("rstmid_cu_imm", cu_immediate, 0);
        check_eq("rstmid_rsp_valid", rsp_valid, 0);
        check_eq("rstmid_rsp_data", rsp_data, 0);
        check_eq("rstmid_rsp_tag", rsp_tag, 0);
        check_eq("rstmid_done_count", done_count, 0);
        check_eq("rstmid_req_ready", req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_eq("rstmid_req_ready_rel", req_ready, 1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) seen++;
            tick();
        end
        check_eq("rstmid_no_rsp", seen, 0);
        check_eq("rstmid_done_after", done_count, 0);

        // done_count wrap
        force dut.done_count = 16'hFFFF;
        tick();
        release dut.done_count;
        tick();
        check_eq("wrap_preload", done_count, 16'hFFFF);
        issue(4'h4, 32'h0000_00F0, 32'h0000_000F, 16'h0000, 4'd1);
        wait_rsp(n);
        check_eq("wrap_rsp_data", rsp_data, 32'h0000_00FF);
        tick();
        check_eq("wrap_done_count", done_count, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
